// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store alignment unit.
// funct3 encodings, FSM state encoding, error codes and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [2:0] {
    StIdle,
    StIssue1,
    StWait1,
    StIssue2,
    StWait2,
    StResp
  } lsu_state_e;

  typedef enum logic [1:0] {
    ErrNone,
    ErrMisalign,
    ErrIllegal,
    ErrBus
  } lsu_err_e;

  function automatic logic funct3_legal(input logic [2:0] funct3, input logic wen,
                                        input logic is64);
    logic ok;
    ok = 1'b1;
    if (funct3 == 3'b111) ok = 1'b0;
    if (wen && funct3[2]) ok = 1'b0;
    // Doubleword and unsigned-word forms only exist on a 64-bit datapath
    if (!is64 && (funct3 == F3_LD || funct3 == F3_LWU)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load extractor: shifts a two-beat window by the byte offset,
// truncates to the access size and sign/zero-extends to XLEN.
module lsu_load_extract
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0]          window,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [2:0]                 funct3,
  output logic [XLEN-1:0]            result
);

  logic [XLEN-1:0] shifted;
  logic            sign;
  int              nbits;

  always_comb begin
    shifted = XLEN'(window >> {off, 3'b000});
    nbits   = 8 << funct3[1:0];
    if (nbits > int'(XLEN)) nbits = int'(XLEN);
    sign    = shifted[nbits-1];
    result  = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      result[i] = (i < nbits) ? shifted[i] : (~funct3[2] & sign);
    end
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: byte strobes and lane shifting for stores, load extraction,
// and optional two-beat splitting of accesses that cross a bus word.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rerr
);

  localparam int unsigned N    = XLEN / 8;
  localparam int unsigned OffW = $clog2(N);
  localparam int unsigned EndW = OffW + 4;

  lsu_state_e          state_q, state_d;
  lsu_err_e            err_q;
  logic                wen_q, cross_q;
  logic [2:0]          funct3_q;
  logic [XLEN-1:0]     base_q;
  logic [OffW-1:0]     off_q;
  logic [2*XLEN-1:0]   wdata_q, win_q;
  logic [2*N-1:0]      wstrb_q;

  logic                accept, cap_lo, cap_hi;
  logic [OffW-1:0]     req_off;
  logic [EndW-1:0]     req_end;
  logic                req_cross, req_illegal;
  logic [2*N-1:0]      req_strb;
  logic [XLEN-1:0]     load_data;

  assign req_off     = req_addr[OffW-1:0];
  assign req_end     = EndW'(req_off) + (EndW'(1) << req_funct3[1:0]);
  assign req_cross   = req_end > EndW'(N);
  assign req_illegal = !funct3_legal(req_funct3, req_wen, XLEN == 64);
  // Access byte mask laid over the two-word window; the high half feeds the second beat
  assign req_strb    = (((2*N)'(1) << (4'd1 << req_funct3[1:0])) - (2*N)'(1)) << req_off;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_illegal || (req_cross && !MISALIGN_SPLIT)) ? StResp : StIssue1;
        end
      end
      StIssue1: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = StWait1;
      end
      StWait1: begin
        if (mem_rvalid) begin
          cap_lo  = 1'b1;
          state_d = (mem_rerr || !cross_q) ? StResp : StIssue2;
        end
      end
      StIssue2: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = StWait2;
      end
      StWait2: begin
        if (mem_rvalid) begin
          cap_hi  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      err_q    <= ErrNone;
      wen_q    <= 1'b0;
      cross_q  <= 1'b0;
      funct3_q <= 3'b000;
      base_q   <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      win_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wen_q    <= req_wen;
        cross_q  <= req_cross;
        funct3_q <= req_funct3;
        base_q   <= req_addr & ~XLEN'(N - 1);
        off_q    <= req_off;
        wdata_q  <= {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
        wstrb_q  <= req_wen ? req_strb : '0;
        win_q    <= '0;
        err_q    <= req_illegal                       ? ErrIllegal  :
                    (req_cross && !MISALIGN_SPLIT)    ? ErrMisalign : ErrNone;
      end
      if (cap_lo) begin
        win_q[XLEN-1:0] <= mem_rdata;
        if (mem_rerr) err_q <= ErrBus;
      end
      if (cap_hi) begin
        win_q[2*XLEN-1:XLEN] <= mem_rdata;
        if (mem_rerr) err_q <= ErrBus;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (state_q == StIssue1) begin
      mem_addr  = base_q;
      mem_wdata = wdata_q[XLEN-1:0];
      mem_wstrb = wstrb_q[N-1:0];
    end else if (state_q == StIssue2) begin
      mem_addr  = base_q + XLEN'(N);
      mem_wdata = wdata_q[2*XLEN-1:XLEN];
      mem_wstrb = wstrb_q[2*N-1:N];
    end
  end

  assign mem_wen   = mem_valid & wen_q;
  assign rsp_err   = (state_q == StResp) && (err_q != ErrNone);
  assign rsp_rdata = (state_q == StResp && err_q == ErrNone && !wen_q) ? load_data : '0;

  lsu_load_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .window(win_q),
    .off   (off_q),
    .funct3(funct3_q),
    .result(load_data)
  );

endmodule
